// File: rtl/key_press_counter_if.sv
// rtl/key_press_counter_if.sv - byte-strobe input and count/key-state outputs of key_press_counter
//
// Purpose : groups the PS/2 byte strobe with the press-count and held-key outputs.
// Signals :
//   data     [7:0]            scan-code byte, valid while ready is high
//   ready                     one-cycle byte strobe
//   mycount  [COUNT_WIDTH-1:0] accepted presses, modulo 2^COUNT_WIDTH
//   key_down                  a tracked key is currently held
//   cur_code [7:0]            scan code of the held or last pressed key
//   cur_ext                   that key was E0-extended
// Modports: master = byte source (PS/2 receiver side), slave = key_press_counter.
interface key_press_counter_if #(
  parameter int COUNT_WIDTH = 8
);
  logic [7:0]             data;
  logic                   ready;
  logic [COUNT_WIDTH-1:0] mycount;
  logic                   key_down;
  logic [7:0]             cur_code;
  logic                   cur_ext;

  modport master (
    output data, ready,
    input  mycount, key_down, cur_code, cur_ext
  );

  modport slave (
    input  data, ready,
    output mycount, key_down, cur_code, cur_ext
  );
endinterface

// File: rtl/key_press_counter.sv
// rtl/key_press_counter.sv - counts distinct PS/2 key presses, ignoring typematic repeats and releases
//
// Purpose : decodes E0/F0 prefixes from the PS/2 byte stream, tracks the held key and
//           counts each new make code once.
// Ports   :
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of key_press_counter_if (data/ready in; mycount, key_down,
//          cur_code, cur_ext out, all registered)
module key_press_counter #(
  parameter int COUNT_WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  key_press_counter_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   key_down_q;
  logic [7:0]             cur_code_q;
  logic                   cur_ext_q;

  logic                   is_make;
  logic                   is_brk;
  logic                   code_ext;
  logic                   filtered;
  logic                   tracked;

  // Keyboard housekeeping bytes; only dropped when no prefix is pending.
  assign filtered = (bus.data == 8'hAA) || (bus.data == 8'hFA) ||
                    (bus.data == 8'hFE) || (bus.data == 8'h00);

  // Incoming code names the key currently being tracked as held.
  assign tracked = key_down_q && (bus.data == cur_code_q) && (code_ext == cur_ext_q);

  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    code_ext  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.data == CODE_EXT) begin
          state_nxt = ST_EXT;
        end else if (bus.data == CODE_BRK) begin
          state_nxt = ST_BRK;
        end else if (!filtered) begin
          is_make = 1'b1;
        end
      end
      ST_EXT: begin
        code_ext = 1'b1;
        if (bus.data == CODE_BRK) begin
          state_nxt = ST_EXT_BRK;
        end else if (bus.data != CODE_EXT) begin
          is_make   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BRK: begin
        if (bus.data == CODE_EXT) begin
          state_nxt = ST_EXT_BRK;
        end else if (bus.data != CODE_BRK) begin
          is_brk    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        code_ext = 1'b1;
        if ((bus.data != CODE_EXT) && (bus.data != CODE_BRK)) begin
          is_brk    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      count_q    <= '0;
      key_down_q <= 1'b0;
      cur_code_q <= 8'h00;
      cur_ext_q  <= 1'b0;
    end else if (bus.ready) begin
      state <= state_nxt;
      // A repeat of the held key is typematic and leaves everything unchanged;
      // any other make (including a second key while one is held) counts and
      // becomes the tracked key.
      if (is_make && !tracked) begin
        count_q    <= count_q + COUNT_WIDTH'(1);
        cur_code_q <= bus.data;
        cur_ext_q  <= code_ext;
        key_down_q <= 1'b1;
      end
      // Only releasing the tracked key clears key_down; releasing a key that
      // was superseded is ignored.
      if (is_brk && tracked) begin
        key_down_q <= 1'b0;
      end
    end
  end

  assign bus.mycount  = count_q;
  assign bus.key_down = key_down_q;
  assign bus.cur_code = cur_code_q;
  assign bus.cur_ext  = cur_ext_q;

endmodule

// File: tb/tb_key_press_counter.sv
// tb/tb_key_press_counter.sv - scoreboard bench for key_press_counter
module tb_key_press_counter;

  logic clk;
  logic reset;

  key_press_counter_if #(.COUNT_WIDTH(8)) bus ();

  key_press_counter #(.COUNT_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    int unsigned kd;
    int unsigned code;
    int unsigned ext;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending prefixes kept as two independent flags.
  int unsigned m_count;
  int unsigned m_kd;
  int unsigned m_code;
  int unsigned m_ext;
  bit          m_pext;
  bit          m_pbrk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_count = 0; m_kd = 0; m_code = 0; m_ext = 0;
    m_pext = 0;  m_pbrk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit housekeeping;
    housekeeping = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'h00);
    if (b == 8'hE0) begin
      m_pext = 1;
    end else if (b == 8'hF0) begin
      m_pbrk = 1;
    end else if (!m_pext && !m_pbrk && housekeeping) begin
      // dropped
    end else begin
      if (m_pbrk) begin
        if (m_kd == 1 && m_code == b && m_ext == m_pext) m_kd = 0;
      end else begin
        if (!(m_kd == 1 && m_code == b && m_ext == m_pext)) begin
          m_count = (m_count + 1) % 256;
          m_code  = b;
          m_ext   = m_pext;
          m_kd    = 1;
        end
      end
      m_pext = 0;
      m_pbrk = 0;
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".mycount"},  bus.mycount,  e.cnt);
    check({tag, ".key_down"}, bus.key_down, e.kd);
    check({tag, ".cur_code"}, bus.cur_code, e.code);
    check({tag, ".cur_ext"},  bus.cur_ext,  e.ext);
  endtask

  // Strobe one byte; consecutive calls keep ready high (back-to-back bytes).
  task automatic send_byte(input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    bus.ready = 1'b1;
    bus.data  = b;
    model_byte(b);
    e = '{m_count, m_kd, m_code, m_ext};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      compare_all($sformatf("byte_%02h", b), e);
    end
  endtask

  // ready low with junk data: nothing may move.
  task automatic idle_check(input int n);
    exp_t e;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.data  = 8'h1C;
    e = '{m_count, m_kd, m_code, m_ext};
    repeat (n) begin
      @(posedge clk);
      #1;
      compare_all("hold", e);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs checked before any edge.
  task automatic do_reset();
    exp_t z;
    @(negedge clk);
    bus.ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    z = '{0, 0, 0, 0};
    compare_all("reset", z);
    model_clear();
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    bus.ready = 1'b0;
    bus.data  = 8'h00;
    model_clear();
    do_reset();

    // Simple press and release
    send_byte(8'h1C);
    check("tp1_count", bus.mycount, 1);
    check("tp1_down", bus.key_down, 1);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("tp1_up", bus.key_down, 0);
    check("tp1_code", bus.cur_code, 8'h1C);
    idle_check(3);

    // Typematic repeat
    do_reset();
    repeat (5) send_byte(8'h1C);
    check("tm_count", bus.mycount, 1);
    check("tm_held", bus.key_down, 1);
    send_byte(8'hF0);
    check("tm_still_held", bus.key_down, 1);
    send_byte(8'h1C);
    check("tm_released", bus.key_down, 0);

    // Extended key vs plain key with the same code
    do_reset();
    send_byte(8'hE0); send_byte(8'h75);
    check("ext_ext1", bus.cur_ext, 1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'h75);
    check("ext_ext0", bus.cur_ext, 0);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("ext_plain_held", bus.key_down, 1);
    send_byte(8'hF0); send_byte(8'h75);
    check("ext_count", bus.mycount, 2);
    check("ext_up", bus.key_down, 0);

    // Filter and overlap
    do_reset();
    send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hFE); send_byte(8'h00);
    check("flt_count", bus.mycount, 0);
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'hF0); send_byte(8'h1C);
    check("ovl_held", bus.key_down, 1);
    send_byte(8'hF0); send_byte(8'h32);
    check("ovl_count", bus.mycount, 2);
    check("ovl_up", bus.key_down, 0);
    // housekeeping byte after a prefix is a real code
    send_byte(8'hE0); send_byte(8'hAA);
    check("pfx_aa_count", bus.mycount, 3);
    send_byte(8'hF0); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'hAA);
    check("pfx_aa_up", bus.key_down, 0);
    idle_check(2);

    // Wrap-around
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h15);
      if (i == 254) check("wrap_ff", bus.mycount, 8'hFF);
      if (i == 255) check("wrap_00", bus.mycount, 8'h00);
      send_byte(8'hF0);
      send_byte(8'h15);
    end

    // Reset mid-prefix
    do_reset();
    send_byte(8'h1C);
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h1C);
    check("rst_pfx_count", bus.mycount, 1);
    check("rst_pfx_down", bus.key_down, 1);

    idle_check(2);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
